vend_ctrl_multi: RTL and testbench
==================================

# vend_ctrl_multi

Parametrised vending controller: successor to the fixed three-item machine, generalised to NUM_ITEMS products with per-item prices, per-item stock counters, bounded credit, cancel/refund and multi-cycle coin-by-coin change return over a valid/ready handshake. Sits between the coin acceptor and item selector on one side and the dispenser and change hopper on the other.

## Interface
- NUM_ITEMS, 4, number of products (1..16)
- CREDIT_W, 8, credit/price width in rupees
- PRICES, {8'd100,8'd75,8'd50,8'd25}, packed NUM_ITEMS*CREDIT_W; item i price at [i*CREDIT_W +: CREDIT_W]; each a nonzero multiple of 5
- MAX_CREDIT, 200, credit ceiling, multiple of 5, < 2**CREDIT_W
- STOCK_W, 4, stock counter width
- INIT_STOCK, 8, per-item stock after reset and after restock
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  coin present this cycle
- coin_type  in  2  0=5, 1=10, 2=20, 3=invalid
- coin_ready  out  1  comb: state==IDLE && !sel_valid && !cancel
- coin_reject  out  1  one-cycle pulse: coin refused (invalid type or would exceed MAX_CREDIT)
- sel_valid  in  1  selection request
- sel_idx  in  4  item index
- cancel  in  1  refund request
- restock  in  1  reload all stock counters to INIT_STOCK
- dispense  out  NUM_ITEMS  one-hot one-cycle pulse
- sold_out  out  1  pulse: selected item stock is 0
- insufficient  out  1  pulse: credit < price
- sel_error  out  1  pulse: sel_idx >= NUM_ITEMS
- change_valid  out  1  a change coin is offered
- change_coin  out  2  0=5, 1=10, 2=20; valid only with change_valid
- change_ready  in  1  hopper accepts offered coin
- credit  out  CREDIT_W  current credit
- busy  out  1  state != IDLE
- empty  out  NUM_ITEMS  bit i set when stock[i]==0

## Operation
- States: IDLE, CHANGE. Reset: IDLE, credit 0, all stock INIT_STOCK, all pulses 0, change_valid 0.
- IDLE priority per cycle: cancel > sel_valid > coin_valid; lower-priority requests in the same cycle are ignored (not queued).
- Cancel: credit>0 -> CHANGE; credit==0 -> no-op.
- Select, checked in order: idx >= NUM_ITEMS -> sel_error; stock[idx]==0 -> sold_out; credit < PRICE[idx] -> insufficient. Any of these: credit and stock unchanged, stay IDLE.
- Select success: dispense[idx] pulses, stock[idx] -= 1, credit -= PRICE[idx]; next state CHANGE if remainder > 0, else IDLE.
- Coin: type 3 or credit+value > MAX_CREDIT -> coin_reject, credit unchanged; else credit += value. Credit == MAX_CREDIT exactly is legal.
- CHANGE: change_valid=1, change_coin = largest of 20/10/5 <= credit (comb from registered credit). On change_valid && change_ready: credit -= coin value; if result 0 -> IDLE. Without change_ready, coin and credit held stable. Coins, selects and cancel ignored in CHANGE (coin_ready=0, no pulses).
- Restock: any state, all counters -> INIT_STOCK; wins over a same-cycle decrement.
- Credit arithmetic in CREDIT_W+1 bits for the overflow compare; credit never exceeds MAX_CREDIT and never underflows.

## Timing
- All pulses (dispense, coin_reject, sold_out, insufficient, sel_error) are registered, asserted exactly one cycle, in the cycle after the request.
- Credit update visible the cycle after acceptance.
- Select success with remainder: dispense pulse and first change_valid in the same cycle (cycle after select).
- Change handshake: one coin per cycle with change_ready tied high; N coins take N cycles; busy deasserts the cycle after the last handshake.
- Reset asserted mid-CHANGE: immediate return to IDLE, credit 0, change_valid 0, stock restored to INIT_STOCK; outstanding change is forfeit.

## Test plan
- Defaults: coins 20,10 (credit 30), select 0 -> dispense=4'b0001, change_coin=5 one handshake, credit 0, busy low next cycle.
- Coins 20x3 (60), select 2 -> insufficient pulse, credit 60; cancel with change_ready low 3 cycles then high -> coins 20,20,20, change_coin stable while stalled.
- Coins 20x10 -> credit 200; coin 5 -> coin_reject, credit 200; coin_type 3 -> coin_reject; select 3 -> dispense[3], change 20,20,20,20,20.
- INIT_STOCK=2: buy item 0 twice (25 each, exact), third attempt with 25 credit -> sold_out, empty[0]=1; restock -> select 0 succeeds.
- Same-cycle cancel+select+coin with credit 15 -> only cancel acts, change 10 then 5; sel_idx=7 with NUM_ITEMS=4 -> sel_error.
- Reset asserted during CHANGE with credit 40 -> next cycle state IDLE, credit 0, change_valid 0, stock INIT_STOCK.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi
//
// Parametrised vending controller. Accepts coins into a bounded credit
// register, sells one of NUM_ITEMS products (each with its own price and
// stock counter), and returns remaining credit coin-by-coin to the change
// hopper over a valid/ready handshake.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high
//   coin_valid    coin present this cycle
//   coin_type     0=5, 1=10, 2=20, 3=invalid
//   coin_ready    controller can take a coin this cycle (combinational)
//   coin_reject   one-cycle pulse: coin refused
//   sel_valid     selection request
//   sel_idx       selected item index
//   cancel        refund request
//   restock       reload every stock counter to INIT_STOCK
//   dispense      one-hot one-cycle pulse for the item sold
//   sold_out      pulse: selected item has no stock
//   insufficient  pulse: credit below the selected item's price
//   sel_error     pulse: sel_idx out of range
//   change_valid  a change coin is offered
//   change_coin   0=5, 1=10, 2=20 (meaningful only with change_valid)
//   change_ready  hopper accepts the offered coin
//   credit        current credit
//   busy          controller is returning change
//   empty         bit i set when item i has no stock
// ---------------------------------------------------------------------------
module vend_ctrl_multi #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd100, 8'd75, 8'd50, 8'd25},
  parameter int                            MAX_CREDIT = 200,
  parameter int                            STOCK_W    = 4,
  parameter int                            INIT_STOCK = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_type,
  output logic                 coin_ready,
  output logic                 coin_reject,
  input  logic                 sel_valid,
  input  logic [3:0]           sel_idx,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] dispense,
  output logic                 sold_out,
  output logic                 insufficient,
  output logic                 sel_error,
  output logic                 change_valid,
  output logic [1:0]           change_coin,
  input  logic                 change_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] empty
);

  typedef logic [CREDIT_W-1:0] cred_t;
  typedef logic [CREDIT_W:0]   cred_ext_t;   // one extra bit for the overflow compare
  typedef logic [STOCK_W-1:0]  stock_t;

  typedef enum logic {IDLE, CHANGE} state_t;

  state_t               state_reg;
  cred_t                credit_reg;
  logic [NUM_ITEMS-1:0] dispense_reg;
  logic                 coin_reject_reg;
  logic                 sold_out_reg;
  logic                 insufficient_reg;
  logic                 sel_error_reg;

  // -------------------------------------------------------------------------
  // Per-item price table, stock counters and selection decode
  // -------------------------------------------------------------------------
  cred_t                price_arr [NUM_ITEMS];
  stock_t               stock_arr [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sel_match;
  logic                 buy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : gen_item
      stock_t stock_reg;

      assign price_arr[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
      assign stock_arr[gi] = stock_reg;
      // No match when sel_idx is out of range, so sel_match doubles as the
      // range check and as the one-hot dispense pattern.
      assign sel_match[gi] = (sel_idx == 4'(gi));
      assign empty[gi]     = (stock_reg == '0);

      // Restock takes precedence over a same-cycle sale.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stock_reg <= stock_t'(INIT_STOCK);
        end else if (restock) begin
          stock_reg <= stock_t'(INIT_STOCK);
        end else if (buy && sel_match[gi]) begin
          stock_reg <= stock_reg - 1'b1;
        end
      end
    end
  endgenerate

  logic   idx_ok;
  cred_t  sel_price;
  stock_t sel_stock;

  assign idx_ok = |sel_match;

  always_comb begin
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_match[i]) begin
        sel_price = price_arr[i];
        sel_stock = stock_arr[i];
      end
    end
  end

  // A sale only happens from IDLE when no cancel outranks the selection.
  assign buy = (state_reg == IDLE) && !cancel && sel_valid && idx_ok &&
               (sel_stock != '0) && (credit_reg >= sel_price);

  // -------------------------------------------------------------------------
  // Coin value and ceiling check
  // -------------------------------------------------------------------------
  cred_ext_t coin_val;
  cred_ext_t coin_sum;
  logic      coin_bad;

  always_comb begin
    case (coin_type)
      2'd0:    coin_val = cred_ext_t'(5);
      2'd1:    coin_val = cred_ext_t'(10);
      2'd2:    coin_val = cred_ext_t'(20);
      default: coin_val = '0;
    endcase
  end

  assign coin_sum = {1'b0, credit_reg} + coin_val;
  assign coin_bad = (coin_type == 2'd3) || (coin_sum > cred_ext_t'(MAX_CREDIT));

  // -------------------------------------------------------------------------
  // Change coin: largest denomination that still fits in the credit.
  // Credit is always a multiple of 5, so the 5 coin covers the remainder.
  // -------------------------------------------------------------------------
  logic [1:0] change_code;
  cred_t      change_amt;

  always_comb begin
    if (credit_reg >= cred_t'(20)) begin
      change_code = 2'd2;
      change_amt  = cred_t'(20);
    end else if (credit_reg >= cred_t'(10)) begin
      change_code = 2'd1;
      change_amt  = cred_t'(10);
    end else begin
      change_code = 2'd0;
      change_amt  = cred_t'(5);
    end
  end

  // -------------------------------------------------------------------------
  // Controller FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      dispense_reg     <= '0;
      coin_reject_reg  <= 1'b0;
      sold_out_reg     <= 1'b0;
      insufficient_reg <= 1'b0;
      sel_error_reg    <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-armed below.
      dispense_reg     <= '0;
      coin_reject_reg  <= 1'b0;
      sold_out_reg     <= 1'b0;
      insufficient_reg <= 1'b0;
      sel_error_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cancel) begin
            if (credit_reg != '0) begin
              state_reg <= CHANGE;
            end
          end else if (sel_valid) begin
            if (!idx_ok) begin
              sel_error_reg <= 1'b1;
            end else if (sel_stock == '0) begin
              sold_out_reg <= 1'b1;
            end else if (!buy) begin
              insufficient_reg <= 1'b1;
            end else begin
              dispense_reg <= sel_match;
              credit_reg   <= credit_reg - sel_price;
              if (credit_reg != sel_price) begin
                state_reg <= CHANGE;
              end
            end
          end else if (coin_valid) begin
            if (coin_bad) begin
              coin_reject_reg <= 1'b1;
            end else begin
              credit_reg <= coin_sum[CREDIT_W-1:0];
            end
          end
        end

        CHANGE: begin
          // Coin and credit stay put until the hopper takes the coin.
          if (change_ready) begin
            if (credit_reg <= change_amt) begin
              credit_reg <= '0;
              state_reg  <= IDLE;
            end else begin
              credit_reg <= credit_reg - change_amt;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign coin_ready   = (state_reg == IDLE) && !sel_valid && !cancel;
  assign coin_reject  = coin_reject_reg;
  assign dispense     = dispense_reg;
  assign sold_out     = sold_out_reg;
  assign insufficient = insufficient_reg;
  assign sel_error    = sel_error_reg;
  assign change_valid = (state_reg == CHANGE);
  assign change_coin  = change_code;
  assign credit       = credit_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_multi
//
// Scoreboard bench for vend_ctrl_multi. The stimulus process issues one
// request per transaction, runs it through a behavioural model of the
// vending rules and queues the output events it expects. A separate monitor
// pops that queue whenever the DUT presents a pulse or a change handshake.
// ---------------------------------------------------------------------------
module tb_vend_ctrl_multi;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int MAXC = 200;
  localparam int SW   = 4;
  localparam int INIT = 2;

  localparam int K_DISP   = 0;
  localparam int K_REJ    = 1;
  localparam int K_SOLD   = 2;
  localparam int K_INSUF  = 3;
  localparam int K_SELERR = 4;
  localparam int K_CHG    = 5;

  logic          clk;
  logic          reset;
  logic          coin_valid;
  logic [1:0]    coin_type;
  logic          coin_ready;
  logic          coin_reject;
  logic          sel_valid;
  logic [3:0]    sel_idx;
  logic          cancel;
  logic          restock;
  logic [N-1:0]  dispense;
  logic          sold_out;
  logic          insufficient;
  logic          sel_error;
  logic          change_valid;
  logic [1:0]    change_coin;
  logic          change_ready;
  logic [CW-1:0] credit;
  logic          busy;
  logic [N-1:0]  empty;

  vend_ctrl_multi #(
    .NUM_ITEMS  (N),
    .CREDIT_W   (CW),
    .PRICES     ({8'd100, 8'd75, 8'd50, 8'd25}),
    .MAX_CREDIT (MAXC),
    .STOCK_W    (SW),
    .INIT_STOCK (INIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_ready   (coin_ready),
    .coin_reject  (coin_reject),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .restock      (restock),
    .dispense     (dispense),
    .sold_out     (sold_out),
    .insufficient (insufficient),
    .sel_error    (sel_error),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .change_ready (change_ready),
    .credit       (credit),
    .busy         (busy),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int price_tab [N];
  int m_credit;
  int m_stock [N];

  // change_ready control: mode 0 = always high, 1 = random; low while cyc < hold_end
  int     ready_mode = 0;
  longint cyc        = 0;
  longint hold_end   = 0;

  function automatic string kname(input int k);
    case (k)
      K_DISP:   return "dispense";
      K_REJ:    return "coin_reject";
      K_SOLD:   return "sold_out";
      K_INSUF:  return "insufficient";
      K_SELERR: return "sel_error";
      K_CHG:    return "change";
      default:  return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Change is paid greedily: biggest coin that still fits.
  task automatic push_change(input int amount);
    int amt;
    amt = amount;
    while (amt > 0) begin
      if (amt >= 20) begin push_ev(K_CHG, 2); amt -= 20; end
      else if (amt >= 10) begin push_ev(K_CHG, 1); amt -= 10; end
      else begin push_ev(K_CHG, 0); amt -= 5; end
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < N; i++) m_stock[i] = INIT;
  endtask

  task automatic model_req(input bit c, input bit s, input int idx,
                           input bit cv, input int ct, input bit rs);
    int val;
    if (c) begin
      push_change(m_credit);
      m_credit = 0;
    end else if (s) begin
      if (idx >= N) push_ev(K_SELERR, 0);
      else if (m_stock[idx] == 0) push_ev(K_SOLD, 0);
      else if (m_credit < price_tab[idx]) push_ev(K_INSUF, 0);
      else begin
        push_ev(K_DISP, idx);
        m_stock[idx] -= 1;
        m_credit -= price_tab[idx];
        push_change(m_credit);
        m_credit = 0;
      end
    end else if (cv) begin
      val = (ct == 0) ? 5 : (ct == 1) ? 10 : (ct == 2) ? 20 : 0;
      if (ct == 3 || m_credit + val > MAXC) push_ev(K_REJ, 0);
      else m_credit += val;
    end
    if (rs) begin
      for (int i = 0; i < N; i++) m_stock[i] = INIT;
    end
  endtask

  function automatic int model_empty();
    int e;
    e = 0;
    for (int i = 0; i < N; i++) if (m_stock[i] == 0) e |= (1 << i);
    return e;
  endfunction

  // Wait for the transaction to settle, then compare the visible state.
  task automatic finish_txn(input string tag);
    int budget;
    budget = 0;
    @(negedge clk); #1;
    while (busy && budget < 500) begin
      @(negedge clk); #1;
      budget++;
    end
    chk({tag, ":busy_timeout"}, int'(busy), 0);
    chk({tag, ":credit"}, int'(credit), m_credit);
    chk({tag, ":empty"}, int'(empty), model_empty());
    chk({tag, ":pending_events"}, exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    $display("txn %-10s credit=%0d empty=%b", tag, credit, empty);
  endtask

  task automatic issue(input string tag, input bit c, input bit s, input int idx,
                       input bit cv, input int ct, input bit rs);
    @(posedge clk); #1;
    chk({tag, ":coin_ready_idle"}, int'(coin_ready), 1);
    model_req(c, s, idx, cv, ct, rs);
    cancel     = c;
    sel_valid  = s;
    sel_idx    = 4'(idx);
    coin_valid = cv;
    coin_type  = 2'(ct);
    restock    = rs;
    #1;
    chk({tag, ":coin_ready_gate"}, int'(coin_ready), (c || s) ? 0 : 1);
    @(posedge clk); #1;
    cancel     = 1'b0;
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    restock    = 1'b0;
    finish_txn(tag);
  endtask

  task automatic coin(input int ct);
    issue("coin", 1'b0, 1'b0, 0, 1'b1, ct, 1'b0);
  endtask

  task automatic sel(input int idx);
    issue("select", 1'b0, 1'b1, idx, 1'b0, 0, 1'b0);
  endtask

  // change_ready driver
  initial begin
    change_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < hold_end) change_ready = 1'b0;
      else if (ready_mode == 1) change_ready = 1'($urandom_range(0, 1));
      else change_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows an output event.
  task automatic take(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got %s(%0d), expected none", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.kind != k || e.val != v) begin
        n_bad++;
        $display("FAIL event: got %s(%0d), expected %s(%0d)", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  initial begin
    logic       prev_stall;
    logic [1:0] prev_coin;
    int         didx;
    prev_stall = 1'b0;
    prev_coin  = 2'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (dispense != '0) begin
          didx = 100 + int'(dispense);
          if ($countones(dispense) == 1) begin
            for (int i = 0; i < N; i++) if (dispense[i]) didx = i;
          end
          take(K_DISP, didx);
        end
        if (coin_reject)  take(K_REJ, 0);
        if (sold_out)     take(K_SOLD, 0);
        if (insufficient) take(K_INSUF, 0);
        if (sel_error)    take(K_SELERR, 0);
        if (change_valid && prev_stall)
          chk("change_coin_stable", int'(change_coin), int'(prev_coin));
        if (change_valid && change_ready) take(K_CHG, int'(change_coin));
        prev_stall = change_valid && !change_ready;
        prev_coin  = change_coin;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    price_tab[0] = 25;
    price_tab[1] = 50;
    price_tab[2] = 75;
    price_tab[3] = 100;
    model_reset();

    reset      = 1'b1;
    coin_valid = 1'b0;
    coin_type  = 2'd0;
    sel_valid  = 1'b0;
    sel_idx    = 4'd0;
    cancel     = 1'b0;
    restock    = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset:credit", int'(credit), 0);
    chk("reset:busy", int'(busy), 0);
    chk("reset:change_valid", int'(change_valid), 0);
    chk("reset:dispense", int'(dispense), 0);
    chk("reset:empty", int'(empty), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 20 + 10, buy item 0 (25): change one 5 coin
    coin(2); coin(1); sel(0);

    // 60 credit, item 2 costs 75; then cancel with the hopper stalled
    coin(2); coin(2); coin(2); sel(2);
    hold_end = cyc + 5;
    issue("cancel", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Fill to the ceiling, reject overflow and invalid coins, buy item 3
    for (int i = 0; i < 10; i++) coin(2);
    coin(0); coin(3); sel(3);

    // Exhaust item 0 (stock 2), sold out, then restock
    issue("restock", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin coin(2); coin(0); sel(0); end
    coin(2); coin(0); sel(0);
    issue("restock", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    sel(0);

    // Same-cycle cancel + select + coin with 15 credit; then bad index
    coin(1); coin(0);
    issue("all3", 1'b1, 1'b1, 0, 1'b1, 2, 1'b0);
    sel(7);

    // Restock in the same cycle as a sale wins over the decrement
    coin(2); coin(2); coin(2);
    issue("sel+rstk", 1'b0, 1'b1, 1, 1'b0, 0, 1'b1);

    // Reset while returning 40 of change
    coin(2); coin(2);
    hold_end = cyc + 50;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("midreset:busy_before", int'(busy), 1);
    chk("midreset:change_valid_before", int'(change_valid), 1);
    @(negedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk); #1;
    chk("midreset:credit", int'(credit), 0);
    chk("midreset:busy", int'(busy), 0);
    chk("midreset:change_valid", int'(change_valid), 0);
    chk("midreset:empty", int'(empty), 0);
    $display("txn midreset  credit=%0d busy=%0d", credit, busy);
    @(posedge clk); #1;
    reset    = 1'b0;
    hold_end = 0;

    // Randomised traffic
    for (int t = 0; t < 250; t++) begin
      ready_mode = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 11));
      if (op <= 5) coin((op == 5) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2)));
      else if (op <= 7) sel(($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)));
      else if (op == 8) issue("cancel", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      else if (op == 9) issue("restock", 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      else issue("combo", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
